fifo_sync_thresh: RTL and testbench
===================================

// Module: fifo_sync_thresh
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the team's basic push/pop FIFO.
//   Adds: any DEPTH (not only powers of two), occupancy count, programmable
//   almost-full/almost-empty thresholds, sticky overflow/underflow errors, synchronous
//   flush, and selectable first-word-fall-through or registered read data.
//   Sits between producer/consumer blocks sharing one clock domain.
// PARAMETERS
//   DEPTH     8         number of entries; integer >= 2, need not be a power of two
//   WIDTH     8         data width in bits
//   AF_LEVEL  DEPTH-1   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  1         almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      1         1: read shows head entry combinationally; 0: read is registered, loaded on accepted pop
// PORTS
//   clk           in   1                   clock, all logic on rising edge
//   rstn          in   1                   reset, synchronous, active-low
//   flush         in   1                   synchronous clear of contents (pointers/count)
//   push          in   1                   write request
//   pop           in   1                   read request
//   write         in   WIDTH               data written on accepted push
//   read          out  WIDTH               read data (see FWFT)
//   count         out  $clog2(DEPTH+1)     current occupancy, 0..DEPTH
//   empty         out  1                   count == 0
//   full          out  1                   count == DEPTH
//   almost_empty  out  1                   count <= AE_LEVEL
//   almost_full   out  1                   count >= AF_LEVEL
//   err_clr       in   1                   clears overflow/underflow
//   overflow      out  1                   sticky: push rejected at least once
//   underflow     out  1                   sticky: pop rejected at least once
// BEHAVIOUR
//   Reset: one clock and one synchronous active-low reset (rstn) sampled on posedge clk; no async path.
//     !rstn at a clock edge -> wptr=rptr=0, count=0, overflow=underflow=0, registered read=0.
//     Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0), read=0.
//     Storage array is not reset. Reset mid-traffic discards all contents and that cycle's push/pop.
//   Priority per edge: rstn > flush > push/pop. flush: pointers/count -> 0, push/pop that
//     cycle ignored, read register -> 0 (FWFT=0); sticky errors NOT cleared by flush.
//   Acceptance (evaluated on pre-edge state):
//     pop_ok  = pop  && !empty
//     push_ok = push && (!full || pop_ok)   -- full + push + pop: both accepted, count stays DEPTH
//     empty + push + pop: push accepted, pop rejected (underflow set), count -> 1.
//   Pointers: increment on accept, wrap explicitly DEPTH-1 -> 0 (no power-of-two modulo).
//   count <= count + push_ok - pop_ok; never exceeds DEPTH, never below 0.
//   Flags: combinational decodes of registered count; valid the cycle after the accepting edge.
//   Errors: overflow <= 1 on push && !push_ok; underflow <= 1 on pop && !pop_ok.
//     err_clr clears both; if a new error occurs the same cycle, set wins.
//   Read data: FWFT=1 -> read = mem[rptr] (0-cycle latency; undefined content when empty).
//     FWFT=0 -> on pop_ok, read <= mem[rptr] (1-cycle latency); holds value otherwise.
//   Write-before-read: an entry pushed at edge N is poppable from edge N+1; no bypass.
// STRUCTURE
//   Package fifo_pkg: function cnt_width(depth) = $clog2(depth+1); typedef of status
//     struct {empty, full, almost_empty, almost_full, overflow, underflow} for reuse.
//   Sub-module fifo_mem: DEPTH x WIDTH array, one sync write port, one async read port.
//   Top holds pointers, count, acceptance logic, flags, sticky errors, read register.
//   Elaboration-time assertions: DEPTH>=2, 1<=AF_LEVEL<=DEPTH, AE_LEVEL<DEPTH.
// TESTING (DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1 unless noted)
//   1 Reset: hold rstn=0 two edges after random traffic -> count=0, empty=1, read=0, errors=0.
//   2 Fill/wrap: push 0x10..0x14, then pop 5, push 0x20..0x22, pop 3 -> reads 0x10..0x14,
//     0x20..0x22 in order; full=1 at count 5; almost_full=1 at count 4; almost_empty=1 at 0,1.
//   3 Overflow: with count=5, push 0xAA alone -> count stays 5, overflow=1; 0xAA never read;
//     err_clr pulse -> overflow=0.
//   4 Simultaneous: full + push 0x55 + pop -> count 5, head advances, 0x55 read last;
//     empty + push 0x66 + pop -> count 1, underflow=1, next pop returns 0x66.
//   5 Flush: count=3, flush with push=1 -> count=0, empty=1, pushed data dropped, errors unchanged.
//   6 FWFT=0 build: push 0x31,0x32; pop at edge N -> read=0x31 after edge N, held until next pop.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the threshold FIFO: count-width helper and a status bundle
// so flag decoding can be reused by neighbouring blocks.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; pointers and count define validity, so contents never need clearing.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO of any depth with occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and FWFT or registered read data.
module fifo_sync_thresh
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b1,
  localparam int CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] write,
  output logic [WIDTH-1:0] read,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_thresh: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_thresh: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_thresh: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow, r_underflow;
  logic             w_pop_ok, w_push_ok, w_we;
  logic [WIDTH-1:0] w_rdata;
  fifo_status_t     w_status;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_status.empty        = (r_count == '0);
    w_status.full         = (r_count == CNT_W'(DEPTH));
    w_status.almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    w_status.almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  // A pop frees a slot on the same edge, so a full FIFO still takes a push alongside a pop.
  assign w_pop_ok  = pop && !w_status.empty;
  assign w_push_ok = push && (!w_status.full || w_pop_ok);
  assign w_we      = w_push_ok && rstn && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= ptr_inc(r_wptr);
      if (w_pop_ok)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // Flush leaves the sticky errors alone; a fresh error outranks err_clr.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (!flush && push && !w_push_ok) r_overflow <= 1'b1;
      else if (err_clr)                 r_overflow <= 1'b0;
      if (!flush && pop && !w_pop_ok)   r_underflow <= 1'b1;
      else if (err_clr)                 r_underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(write),
    .i_raddr(r_rptr),
    .o_rdata(w_rdata)
  );

  if (FWFT) begin : g_fwft
    assign read = w_rdata;
  end else begin : g_reg_read
    logic [WIDTH-1:0] r_read;
    always_ff @(posedge clk) begin
      if (!rstn || flush) r_read <= '0;
      else if (w_pop_ok)  r_read <= w_rdata;
    end
    assign read = r_read;
  end

  assign count        = r_count;
  assign empty        = w_status.empty;
  assign full         = w_status.full;
  assign almost_empty = w_status.almost_empty;
  assign almost_full  = w_status.almost_full;
  assign overflow     = w_status.overflow;
  assign underflow    = w_status.underflow;

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Directed bench: DUT a is FWFT, DUT b uses registered read data; both share stimulus.
module tb_fifo_sync_thresh;

  logic       clk = 1'b0;
  logic       rstn, flush, push, pop, err_clr;
  logic [7:0] wdata;

  logic [7:0] read_a, read_b;
  logic [2:0] count_a, count_b;
  logic       empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
  logic       empty_b, full_b, ae_b, af_b, ovf_b, udf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_sync_thresh #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) u_dut_a (
    .clk(clk), .rstn(rstn), .flush(flush), .push(push), .pop(pop), .write(wdata),
    .read(read_a), .count(count_a), .empty(empty_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a), .err_clr(err_clr),
    .overflow(ovf_a), .underflow(udf_a)
  );

  fifo_sync_thresh #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b0)) u_dut_b (
    .clk(clk), .rstn(rstn), .flush(flush), .push(push), .pop(pop), .write(wdata),
    .read(read_b), .count(count_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b), .err_clr(err_clr),
    .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic cyc(input logic p_push, input logic p_pop, input logic [7:0] d);
    push = p_push; pop = p_pop; wdata = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    rstn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (count_a !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_a); end
    n_checks++; if ({empty_a, full_a, ae_a, af_a} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got %b want 1010", {empty_a, full_a, ae_a, af_a}); end
    n_checks++; if ({ovf_a, udf_a, ovf_b, udf_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_errors: got %b want 0000", {ovf_a, udf_a, ovf_b, udf_b}); end
    n_checks++; if (read_b !== 8'h00) begin n_fail++; $display("FAIL reset_read_reg: got %h want 00", read_b); end
    n_checks++; if (count_b !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d want 0", count_b); end
    rstn = 1'b1;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
      n_checks++; if (count_a !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count_a, i + 1); end
      n_checks++; if (af_a !== (i + 1 >= 4)) begin n_fail++; $display("FAIL fill_almost_full: got %b at count %0d", af_a, i + 1); end
      n_checks++; if (full_a !== (i + 1 == 5)) begin n_fail++; $display("FAIL fill_full: got %b at count %0d", full_a, i + 1); end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (read_a !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL drain_read: got %h want %h", read_a, 8'(8'h10 + i)); end
      cyc(1'b0, 1'b1, 8'h00);
      n_checks++; if (ae_a !== (4 - i <= 1)) begin n_fail++; $display("FAIL drain_almost_empty: got %b at count %0d", ae_a, 4 - i); end
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (read_a !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL wrap_read: got %h want %h", read_a, 8'(8'h20 + i)); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    cyc(1'b1, 1'b0, 8'hAA);
    n_checks++; if (count_a !== 3'd5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", count_a); end
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_a); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (read_a !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL ovf_read: got %h want %h", read_a, 8'(8'h40 + i)); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    n_checks++; if (count_a !== 3'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", count_a); end
    pulse_err_clr();
    n_checks++; if ({ovf_a, udf_a} !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got %b want 00", {ovf_a, udf_a}); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
    cyc(1'b1, 1'b1, 8'h55);
    n_checks++; if (count_a !== 3'd5) begin n_fail++; $display("FAIL sim_full_count: got %0d want 5", count_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL sim_full_no_ovf: got %b want 0", ovf_a); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (read_a !== 8'(8'h51 + i)) begin n_fail++; $display("FAIL sim_full_read: got %h want %h", read_a, 8'(8'h51 + i)); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    cyc(1'b1, 1'b1, 8'h66);
    n_checks++; if (count_a !== 3'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d want 1", count_a); end
    n_checks++; if (udf_a !== 1'b1) begin n_fail++; $display("FAIL sim_empty_udf: got %b want 1", udf_a); end
    n_checks++; if (read_a !== 8'h66) begin n_fail++; $display("FAIL sim_empty_read: got %h want 66", read_a); end
    cyc(1'b0, 1'b1, 8'h00);
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL sim_empty_after: got %b want 1", empty_a); end
    pulse_err_clr();
  endtask

  task automatic test_flush();
    cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h70 + i));
    n_checks++; if (count_a !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count_a); end
    flush = 1'b1;
    cyc(1'b1, 1'b0, 8'h77);
    flush = 1'b0;
    n_checks++; if ({count_a, empty_a} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL flush_state: got count %0d empty %b want 0 1", count_a, empty_a); end
    n_checks++; if ({ovf_a, udf_a} !== 2'b01) begin n_fail++; $display("FAIL flush_errors: got %b want 01", {ovf_a, udf_a}); end
    cyc(1'b1, 1'b0, 8'h78);
    n_checks++; if (read_a !== 8'h78) begin n_fail++; $display("FAIL flush_dropped: got %h want 78", read_a); end
    cyc(1'b0, 1'b1, 8'h00);
    pulse_err_clr();
  endtask

  task automatic test_registered_read();
    n_checks++; if (read_b !== 8'h78) begin n_fail++; $display("FAIL reg_prev_pop: got %h want 78", read_b); end
    flush = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    flush = 1'b0;
    n_checks++; if (read_b !== 8'h00) begin n_fail++; $display("FAIL reg_flush_read: got %h want 00", read_b); end
    cyc(1'b1, 1'b0, 8'h31);
    cyc(1'b1, 1'b0, 8'h32);
    n_checks++; if ({read_b, count_b} !== {8'h00, 3'd2}) begin n_fail++; $display("FAIL reg_before_pop: got %h/%0d want 00/2", read_b, count_b); end
    cyc(1'b0, 1'b1, 8'h00);
    n_checks++; if (read_b !== 8'h31) begin n_fail++; $display("FAIL reg_pop1: got %h want 31", read_b); end
    cyc(1'b0, 1'b0, 8'h00);
    n_checks++; if (read_b !== 8'h31) begin n_fail++; $display("FAIL reg_hold1: got %h want 31", read_b); end
    cyc(1'b0, 1'b1, 8'h00);
    n_checks++; if (read_b !== 8'h32) begin n_fail++; $display("FAIL reg_pop2: got %h want 32", read_b); end
    cyc(1'b0, 1'b1, 8'h00);
    n_checks++; if ({read_b, udf_b} !== {8'h32, 1'b1}) begin n_fail++; $display("FAIL reg_empty_pop: got %h/%b want 32/1", read_b, udf_b); end
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; wdata = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    test_reset();
    test_fill_wrap();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_registered_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
